// File: rtl/alu_result_pkg.sv
// Shared types and helpers for the ALU result stage: operand size codes,
// the buffered result entry, and the size mask / sign-bit helpers.
package alu_result_pkg;

  localparam int DATA_W_C    = 64;
  localparam int REG_IDX_W_C = 5;

  typedef enum logic [1:0] {
    BYTES_8  = 2'd0,
    BYTES_16 = 2'd1,
    BYTES_32 = 2'd2,
    BYTES_64 = 2'd3
  } arg_size_e;

  typedef struct packed {
    logic [DATA_W_C-1:0]    result;
    logic [REG_IDX_W_C-1:0] dest;
  } result_entry_t;

  function automatic logic [DATA_W_C-1:0] size_mask(input arg_size_e size);
    logic [DATA_W_C-1:0] mask;
    case (size)
      BYTES_8:  mask = 64'h0000_0000_0000_00FF;
      BYTES_16: mask = 64'h0000_0000_0000_FFFF;
      BYTES_32: mask = 64'h0000_0000_FFFF_FFFF;
      default:  mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

  function automatic logic [5:0] size_msb(input arg_size_e size);
    logic [5:0] msb;
    case (size)
      BYTES_8:  msb = 6'd7;
      BYTES_16: msb = 6'd15;
      BYTES_32: msb = 6'd31;
      default:  msb = 6'd63;
    endcase
    return msb;
  endfunction

endpackage

// File: rtl/alu_result_skid.sv
// Two-entry in-order skid buffer for the ALU result stage; head entry is
// presented straight from flops so the outputs stay registered.
module alu_result_skid
  import alu_result_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  result_entry_t push_entry,
  input  logic          pop_ready,
  output logic          in_ready,
  output logic          out_valid,
  output result_entry_t head_entry
);

  result_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign pop = (cnt_q != 2'd0) & pop_ready;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_entry;
          else               e1_d = push_entry;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        // Push only happens below two entries, so here the count is 1 and stays 1.
        2'b11: e0_d = push_entry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready   = (cnt_q != 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign head_entry = e0_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: size masking, carry/zero/sign flag register and writeback
// handshake. Define ALU_RESULT_SKID_EN for a 2-entry skid buffer.
module alu_result_stage
  import alu_result_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_result,
  input  logic                 in_carry,
  input  logic [1:0]           in_size,
  input  logic [REG_IDX_W-1:0] in_dest,
  input  logic                 in_upd_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_result,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 sign_flag
);

  arg_size_e         size;
  logic [DATA_W-1:0] masked;
  logic              accept;
  result_entry_t     in_entry, head_entry;
  logic              carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;

  assign size     = arg_size_e'(in_size);
  assign masked   = in_result & size_mask(size);
  // A flush cancels any coincident accept, including its flag write.
  assign accept   = in_valid & in_ready & ~flush;
  assign in_entry = '{result: masked, dest: in_dest};

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    if (accept && in_upd_flags) begin
      carry_d = in_carry;
      zero_d  = (masked == '0);
      sign_d  = masked[size_msb(size)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
    end
  end

`ifdef ALU_RESULT_SKID_EN
  alu_result_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (accept),
    .push_entry (in_entry),
    .pop_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .head_entry (head_entry)
  );
`else
  logic          valid_q, valid_d;
  result_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = in_entry;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign in_ready   = ~valid_q;
  assign out_valid  = valid_q;
  assign head_entry = entry_q;
`endif

  assign out_result = head_entry.result;
  assign out_dest   = head_entry.dest;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign sign_flag  = sign_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: masking, flags, ordering, backpressure,
// flush and asynchronous reset.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_carry, in_upd_flags;
  logic [63:0] in_result, out_result;
  logic [1:0]  in_size;
  logic [4:0]  in_dest, out_dest;
  logic        out_valid, out_ready, carry_flag, zero_flag, sign_flag;

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];
  int idx;
  logic rdy;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_size(in_size), .in_dest(in_dest),
    .in_upd_flags(in_upd_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .sign_flag(sign_flag)
  );

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Records every writeback transfer; sampled mid-cycle when inputs are settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) got_q.push_back({out_dest, out_result});
  end

  task automatic drive(input logic [63:0] res, input logic [1:0] sz, input logic cy,
                       input logic upd, input logic [4:0] dst);
    in_valid = 1'b1; in_result = res; in_size = sz; in_carry = cy;
    in_upd_flags = upd; in_dest = dst;
  endtask

  // Drives one op from the next falling edge until accepted; returns just after the accepting edge.
  task automatic send(input logic [63:0] res, input logic [1:0] sz, input logic cy,
                      input logic upd, input logic [4:0] dst, input logic [63:0] exp_res);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      drive(res, sz, cy, upd, dst);
      done = in_ready;
      @(posedge clk);
    end
    if (done) exp_q.push_back({dst, exp_res});
    else check("send_timeout", {68'd0, done}, 69'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic c, input logic z, input logic s);
    check(tag, {66'd0, carry_flag, zero_flag, sign_flag}, {66'd0, c, z, s});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
    in_size = 2'd0; in_dest = '0; in_upd_flags = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {68'd0, out_valid}, 69'd0);
    check("rst_out", {out_dest, out_result}, 69'd0);
    check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {68'd0, in_ready}, 69'd1);

    // 1: byte op, negative result
    send(64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b0, 1'b1, 5'd3, 64'h80);
    idle();
    check("t1_valid", {68'd0, out_valid}, 69'd1);
    check("t1_out", {out_dest, out_result}, {5'd3, 64'h80});
    check_flags("t1_flags", 1'b0, 1'b0, 1'b1);

    // 2: 32-bit op whose masked result is zero, with carry
    send(64'h1_0000_0000, 2'd2, 1'b1, 1'b1, 5'd5, 64'h0);
    idle();
    check("t2_out", {out_dest, out_result}, {5'd5, 64'h0});
    check_flags("t2_flags", 1'b1, 1'b1, 1'b0);

    // 3: back-to-back, second op leaves flags alone
    send(64'hDEAD_0000_0000_8000, 2'd1, 1'b0, 1'b1, 5'd11, 64'h8000);
    send(64'h0, 2'd3, 1'b1, 1'b0, 5'd12, 64'h0);
    idle();
    check_flags("t3_flags", 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_drained", {68'd0, out_valid}, 69'd0);

    // 4: stream under a 3-cycle out_ready stall
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      case (idx)
        0: drive(64'h1234_5678_9ABC_DEF0, 2'd3, 1'b0, 1'b0, 5'd7);
        1: drive(64'hFFFF_FFFF_0000_00FF, 2'd1, 1'b0, 1'b0, 5'd8);
        default: drive(64'hAAAA_BBBB_CCCC_DDDD, 2'd2, 1'b0, 1'b0, 5'd9);
      endcase
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        case (idx)
          0: exp_q.push_back({5'd7, 64'h1234_5678_9ABC_DEF0});
          1: exp_q.push_back({5'd8, 64'h0000_0000_0000_00FF});
          default: exp_q.push_back({5'd9, 64'h0000_0000_CCCC_DDDD});
        endcase
        idx++;
      end
    end
    @(negedge clk);
`ifdef ALU_RESULT_SKID_EN
    check("t4_accepts", 69'(idx), 69'd2);
`else
    check("t4_accepts", 69'(idx), 69'd1);
`endif
    check("t4_in_ready", {68'd0, in_ready}, 69'd0);
    out_ready = 1'b1;
    if (idx < 2) send(64'hFFFF_FFFF_0000_00FF, 2'd1, 1'b0, 1'b0, 5'd8, 64'h00FF);
    send(64'hAAAA_BBBB_CCCC_DDDD, 2'd2, 1'b0, 1'b0, 5'd9, 64'hCCCC_DDDD);
    send(64'h0000_0000_0000_0055, 2'd0, 1'b0, 1'b0, 5'd10, 64'h55);
    idle();
    repeat (4) @(negedge clk);
    check("t4_drained", {68'd0, out_valid}, 69'd0);
    check_flags("t4_flags", 1'b0, 1'b0, 1'b1);

    // 5: flush coincident with accept while one entry is held
    out_ready = 1'b0;
    send(64'h7F, 2'd0, 1'b1, 1'b1, 5'd13, 64'h7F);
    void'(exp_q.pop_back());
    @(negedge clk);
    check_flags("t5_pre_flags", 1'b1, 1'b0, 1'b0);
    drive(64'h0, 2'd0, 1'b0, 1'b1, 5'd14);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("t5_valid", {68'd0, out_valid}, 69'd0);
    check_flags("t5_flags", 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_ghost", {68'd0, out_valid}, 69'd0);

    // 6: asynchronous reset while an entry is valid
    out_ready = 1'b0;
    send(64'h80, 2'd0, 1'b1, 1'b1, 5'd15, 64'h80);
    void'(exp_q.pop_back());
    idle();
    check("t6_valid_before", {68'd0, out_valid}, 69'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_valid_async", {68'd0, out_valid}, 69'd0);
    check_flags("t6_flags_async", 1'b0, 1'b0, 1'b0);
    check("t6_out_async", {out_dest, out_result}, 69'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Writeback stream must match acceptance order exactly
    check("order_count", 69'(got_q.size()), 69'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("order_%0d", i), got_q[i], exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
